spi_slave_phy: RTL and testbench
================================

Name: spi_slave_phy

Overview:
- SPI mode-3 slave front end (CPOL=1, CPHA=1, MSB first, active-low chip select), clocked entirely by the system clock.
- Oversamples the pad-level `spi_sck`, `spi_cs_n` and `spi_mosi`, deserialises MOSI into bytes and serialises a transmit byte onto MISO.
- Sits between the top-level pads and the command/LED controller that consumes received bytes and supplies reply bytes.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (must be ≥2).
- TX_IDLE, 8'hFF, byte shifted out when no transmit byte is pending.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- spi_sck  in  1  SPI clock from the pad; idles high.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  serial data in.
- spi_miso  out  1  serial data out.
- spi_miso_oe  out  1  MISO output enable; high while CS is active.
- rx_data  out  8  last complete received byte; held until the next byte completes.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_data  in  8  next reply byte.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  holding register empty; transfer occurs when tx_valid && tx_ready.
- tx_underrun  out  1  one-cycle pulse when TX_IDLE was substituted.
- frame_start  out  1  one-cycle pulse on the synchronised CS falling edge.
- frame_end  out  1  one-cycle pulse on the synchronised CS rising edge.
- frame_partial  out  1  valid together with frame_end; high if the bit count was nonzero (partial byte discarded).

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-high on `rst`. All flops clear immediately on assertion.
- Reset values:
  - spi_miso=1, spi_miso_oe=0, rx_data=0, rx_valid=0, tx_ready=1, tx_underrun=0, frame_start=0, frame_end=0, frame_partial=0.
  - Bit counter=0, holding register empty, synchronisers preset to idle (sck=1, cs_n=1, mosi=0).
- Synchronisers and edge detection:
  - SCK, CS_n and MOSI each pass through SYNC_STAGES flops, then one edge-detect register.
  - An SCK edge is acted on SYNC_STAGES+1 clk cycles after the pin changes.
  - Supported SCK frequency: ≤ clk/8.
- States:
  - IDLE (CS inactive): SCK edges ignored; spi_miso=1, oe=0.
  - ACTIVE (CS low).
  - IDLE→ACTIVE on the synchronised CS fall: bit counter=0, frame_start pulses.
  - ACTIVE→IDLE on the synchronised CS rise: frame_end pulses; frame_partial=(bitcnt!=0); the partial RX byte is discarded; TX shift register cleared; holding register retained.
- Falling SCK edge while ACTIVE:
  - If bitcnt==0, load the TX shift register from the holding register (holding becomes empty, tx_ready=1 on the next cycle). If the holding register is empty, load TX_IDLE and pulse tx_underrun.
  - Drive spi_miso with the current MSB, then shift left.
- Rising SCK edge while ACTIVE:
  - Shift the synchronised MOSI into the RX register LSB; bitcnt increments.
  - On the 8th bit, bitcnt wraps to 0, and rx_data is updated with rx_valid pulsing in the cycle after that edge is detected.
- Holding register:
  - Accepts a byte whenever empty, including mid-byte and while in IDLE.
  - If the load and an accept happen in the same cycle, the load takes the old content first and the new byte is then written; tx_ready=0 afterwards.
- Simultaneous CS rise and SCK edge in the same cycle: the CS rise wins and the edge is ignored.
- A rising SCK edge before any falling edge in a frame is still sampled; MISO is then unspecified for that bit.
- rx_valid and frame_end may both assert in the same cycle only if CS rises exactly after bit 8; in that case frame_partial=0.
- Reset mid-frame: everything clears. The next activity requires a fresh CS fall after reset is released.

Decomposition:
- Package spi_pkg holds:
  - SPI_BYTE_W=8 and the bit-counter width constant.
  - The state enum {SPI_IDLE, SPI_ACTIVE}.
  - TX_IDLE_DEFAULT=8'hFF.
- One sub-module, spi_sync_edge: an N-stage synchroniser plus rise/fall pulse outputs, with the reset value as a parameter. Instantiated for SCK and CS_n; MOSI uses only its synchronised output.

Test Plan:
- Reset: CS high, assert rst mid-stream → all outputs at reset values in the same cycle; oe=0, miso=1.
- RX bytes: send 0x43 then 0x7E in separate CS frames at SCK = clk/10 → rx_valid pulses twice with rx_data 0x43 then 0x7E; frame_start/frame_end pulse twice each; frame_partial=0.
- TX byte: preload tx_data=0xA5, run an 8-bit frame → MISO bits sampled on rising SCK read 1,0,1,0,0,1,0,1; tx_ready returns to 1 after the first falling edge.
- Underrun: no tx_valid, 2-byte frame → MISO reads 0xFF,0xFF; tx_underrun pulses twice.
- Partial frame: CS rises after 5 bits → no rx_valid; frame_end=1 with frame_partial=1. The next full frame receiving 0x43 is correct.
- Back-to-back: 2 bytes in one CS frame with tx_valid refilled after each tx_ready → receive 0x43,0x7E and send 0x12,0x34; no underrun.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the SPI mode-3 slave front end.
//   SPI_BYTE_W      : bits per SPI byte
//   SPI_CNT_W       : width of the in-byte bit counter
//   TX_IDLE_DEFAULT : byte shifted out when no reply byte is pending
//   spi_state_e     : chip-select state (idle / active frame)
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int SPI_BYTE_W = 8;
   localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);

   localparam logic [SPI_BYTE_W-1:0] TX_IDLE_DEFAULT = 8'hFF;

   typedef enum logic {
      SPI_IDLE   = 1'b0,
      SPI_ACTIVE = 1'b1
   } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// N-stage synchroniser for an asynchronous pad signal, followed by one
// edge-detect register that yields single-cycle rise/fall pulses.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   i_d      : asynchronous input from the pad
//   o_sync   : synchronised level
//   o_rise   : one-cycle pulse on a synchronised 0->1 transition
//   o_fall   : one-cycle pulse on a synchronised 1->0 transition
// Parameters:
//   STAGES   : synchroniser depth (>= 2)
//   RST_VAL  : idle level the chain is preset to, so reset creates no edge
// -----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   // NOTE: sequential state uses non-blocking assignments so every flop in the
   // chain samples its predecessor's pre-edge value; blocking here would
   // collapse the synchroniser into a single stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= {STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_d};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_sync = r_sync[STAGES-1];
   assign o_rise =  o_sync & ~r_prev;
   assign o_fall = ~o_sync &  r_prev;

endmodule : spi_sync_edge

// File: rtl/spi_slave_phy.sv
// -----------------------------------------------------------------------------
// spi_slave_phy
// SPI mode-3 slave front end (CPOL=1, CPHA=1, MSB first, active-low CS),
// running entirely on the system clock by oversampling the pads.
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   spi_sck/cs_n/mosi : pad inputs (SCK idles high)
//   spi_miso          : serial data out (1 while idle)
//   spi_miso_oe       : MISO enable, high while the frame is active
//   rx_data/rx_valid  : last complete received byte, one-cycle update pulse
//   tx_data/tx_valid  : next reply byte offered by the controller
//   tx_ready          : holding register empty
//   tx_underrun       : pulse when TX_IDLE was substituted for a missing byte
//   frame_start/end   : pulses on synchronised CS fall / rise
//   frame_partial     : with frame_end, high if a partial byte was discarded
// -----------------------------------------------------------------------------
module spi_slave_phy
   import spi_pkg::*;
#(
   parameter int                    SYNC_STAGES = 2,
   parameter logic [SPI_BYTE_W-1:0] TX_IDLE     = TX_IDLE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spi_sck,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   output logic [SPI_BYTE_W-1:0] rx_data,
   output logic                  rx_valid,
   input  logic [SPI_BYTE_W-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic                  tx_underrun,
   output logic                  frame_start,
   output logic                  frame_end,
   output logic                  frame_partial
);

   // ---------------------------------------------------------------- sync
   logic w_sck_rise, w_sck_fall, w_sck_sync;
   logic w_cs_rise,  w_cs_fall,  w_cs_sync;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
      .clk    (clk),
      .rst    (rst),
      .i_d    (spi_sck),
      .o_sync (w_sck_sync),
      .o_rise (w_sck_rise),
      .o_fall (w_sck_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk    (clk),
      .rst    (rst),
      .i_d    (spi_cs_n),
      .o_sync (w_cs_sync),
      .o_rise (w_cs_rise),
      .o_fall (w_cs_fall)
   );

   // MOSI needs only its level; its chain has the same depth as SCK's so the
   // sampled bit lines up with the detected rising edge.
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   w_mosi;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_mosi_sync <= '0;
      else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
   end

   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

   // ---------------------------------------------------------------- state
   spi_state_e            r_state;
   logic [SPI_CNT_W-1:0]  r_bitcnt;
   logic [SPI_BYTE_W-2:0] r_rx_shift;   // first 7 bits; the 8th goes straight to rx_data
   logic [SPI_BYTE_W-1:0] r_tx_shift;
   logic [SPI_BYTE_W-1:0] r_hold;
   logic                  r_hold_full;
   logic                  r_miso;

   logic                  w_active;
   logic                  w_edge_ok;    // frame active and not ending this cycle
   logic                  w_load;
   logic                  w_accept;
   logic [SPI_BYTE_W-1:0] w_load_byte;

   assign w_active    = (r_state == SPI_ACTIVE);
   // A CS rise in the same cycle as an SCK edge ends the frame; the edge is dropped.
   assign w_edge_ok   = w_active && !w_cs_rise;
   assign w_load      = w_edge_ok && w_sck_fall && (r_bitcnt == '0);
   assign w_accept    = tx_valid && !r_hold_full;
   assign w_load_byte = r_hold_full ? r_hold : TX_IDLE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= SPI_IDLE;
         r_bitcnt      <= '0;
         r_rx_shift    <= '0;
         r_tx_shift    <= '0;
         r_hold        <= '0;
         r_hold_full   <= 1'b0;
         r_miso        <= 1'b1;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         tx_underrun   <= 1'b0;
         frame_start   <= 1'b0;
         frame_end     <= 1'b0;
         frame_partial <= 1'b0;
      end else begin
         rx_valid      <= 1'b0;
         tx_underrun   <= 1'b0;
         frame_start   <= 1'b0;
         frame_end     <= 1'b0;
         frame_partial <= 1'b0;

         // Holding register: a load reads the old content (or finds it empty)
         // before a same-cycle accept writes the new byte.
         r_hold_full <= w_accept | (r_hold_full & ~w_load);
         if (w_accept) r_hold <= tx_data;

         if (!w_active) begin
            r_miso <= 1'b1;
            if (w_cs_fall) begin
               r_state     <= SPI_ACTIVE;
               r_bitcnt    <= '0;
               frame_start <= 1'b1;
            end
         end else if (w_cs_rise) begin
            r_state       <= SPI_IDLE;
            frame_end     <= 1'b1;
            frame_partial <= (r_bitcnt != '0);
            r_bitcnt      <= '0;
            r_tx_shift    <= '0;
            r_miso        <= 1'b1;
         end else if (w_sck_fall) begin
            if (r_bitcnt == '0) begin
               r_miso      <= w_load_byte[SPI_BYTE_W-1];
               r_tx_shift  <= {w_load_byte[SPI_BYTE_W-2:0], 1'b0};
               tx_underrun <= !r_hold_full;
            end else begin
               r_miso     <= r_tx_shift[SPI_BYTE_W-1];
               r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
            end
         end else if (w_sck_rise) begin
            r_rx_shift <= {r_rx_shift[SPI_BYTE_W-3:0], w_mosi};
            r_bitcnt   <= r_bitcnt + 1'b1;   // wraps to 0 after the 8th bit
            if (r_bitcnt == SPI_CNT_W'(SPI_BYTE_W-1)) begin
               rx_data  <= {r_rx_shift, w_mosi};
               rx_valid <= 1'b1;
            end
         end
      end
   end

   assign spi_miso_oe = w_active;
   assign spi_miso    = w_active ? r_miso : 1'b1;
   assign tx_ready    = !r_hold_full;

   // The synchronised SCK/CS levels are only consumed through their edges.
   logic w_unused;
   assign w_unused = w_sck_sync ^ w_cs_sync;

endmodule : spi_slave_phy

// File: tb/tb_spi_slave_phy.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_phy
// Directed bench for the SPI mode-3 slave front end. A master model drives
// SCK at clk/10; expected received bytes and frame-end flags are queued by
// the stimulus and consumed by a monitor whenever the DUT pulses rx_valid or
// frame_end. MISO bytes and pulse counts are compared against constants.
// -----------------------------------------------------------------------------
module tb_spi_slave_phy;

   logic       clk = 1'b0;
   logic       rst;
   logic       spi_sck, spi_cs_n, spi_mosi;
   logic       spi_miso, spi_miso_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready, tx_underrun;
   logic       frame_start, frame_end, frame_partial;

   spi_slave_phy dut (
      .clk           (clk),
      .rst           (rst),
      .spi_sck       (spi_sck),
      .spi_cs_n      (spi_cs_n),
      .spi_mosi      (spi_mosi),
      .spi_miso      (spi_miso),
      .spi_miso_oe   (spi_miso_oe),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx_underrun   (tx_underrun),
      .frame_start   (frame_start),
      .frame_end     (frame_end),
      .frame_partial (frame_partial)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int n_underrun = 0;
   int n_fstart   = 0;

   logic [7:0] exp_rx[$];
   logic       exp_partial[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ------------------------------------------------------------ monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (tx_underrun) n_underrun++;
            if (frame_start) n_fstart++;
            if (rx_valid) begin
               if (exp_rx.size() == 0) check("rx_unexpected", 32'(rx_data), 32'hDEAD);
               else check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
            if (frame_end) begin
               if (exp_partial.size() == 0) check("frame_end_unexpected", 1, 0);
               else check("frame_partial", 32'(frame_partial), 32'(exp_partial.pop_front()));
            end
         end
      end
   end

   // ------------------------------------------------------------ master model
   // Shifts nbits MSB-first from mosi_b; MISO is sampled just before each
   // rising SCK edge, as a mode-3 master would.
   task automatic spi_xfer(input logic [7:0] mosi_b, input int nbits, output logic [7:0] miso_b);
      miso_b = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_sck  = 1'b0;
         spi_mosi = mosi_b[i];
         tick(5);
         miso_b[i] = spi_miso;
         spi_sck   = 1'b1;
         tick(5);
      end
   endtask

   task automatic cs_begin();
      spi_cs_n = 1'b0;
      tick(5);
      check("miso_oe_active", 32'(spi_miso_oe), 1);
   endtask

   task automatic cs_end(input logic partial);
      exp_partial.push_back(partial);
      tick(5);
      spi_cs_n = 1'b1;
      tick(8);
   endtask

   task automatic offer_tx(input logic [7:0] b);
      int waited = 0;
      while (!tx_ready && waited < 50) begin
         tick(1);
         waited++;
      end
      if (!tx_ready) check("tx_ready_timeout", 0, 1);
      tx_data  = b;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   // Single-byte frame with expected RX pushed before the transfer.
   task automatic byte_frame(input logic [7:0] mosi_b, output logic [7:0] miso_b);
      exp_rx.push_back(mosi_b);
      cs_begin();
      spi_xfer(mosi_b, 8, miso_b);
      cs_end(1'b0);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      logic [7:0] m0, m1;
      int u0;

      rst = 1'b1;
      spi_sck = 1'b1; spi_cs_n = 1'b1; spi_mosi = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0;
      tick(3);
      check("rst_miso",        32'(spi_miso), 1);
      check("rst_oe",          32'(spi_miso_oe), 0);
      check("rst_rx_data",     32'(rx_data), 0);
      check("rst_tx_ready",    32'(tx_ready), 1);
      check("rst_pulses",      32'({rx_valid, tx_underrun, frame_start, frame_end, frame_partial}), 0);
      rst = 1'b0;
      tick(4);

      // RX bytes in separate frames; nothing offered, so MISO idles at FF.
      u0 = n_underrun;
      byte_frame(8'h43, m0);
      check("rx1_miso_idle", 32'(m0), 32'hFF);
      byte_frame(8'h7E, m1);
      check("rx2_miso_idle", 32'(m1), 32'hFF);
      check("rx_underruns", 32'(n_underrun - u0), 2);

      // TX byte A5 preloaded.
      offer_tx(8'hA5);
      check("tx_ready_full", 32'(tx_ready), 0);
      u0 = n_underrun;
      byte_frame(8'h00, m0);
      check("tx_miso_a5", 32'(m0), 32'hA5);
      check("tx_ready_after", 32'(tx_ready), 1);
      check("tx_no_underrun", 32'(n_underrun - u0), 0);

      // Underrun across two bytes of one frame.
      u0 = n_underrun;
      exp_rx.push_back(8'h55);
      exp_rx.push_back(8'hAA);
      cs_begin();
      spi_xfer(8'h55, 8, m0);
      spi_xfer(8'hAA, 8, m1);
      cs_end(1'b0);
      check("udr_miso0", 32'(m0), 32'hFF);
      check("udr_miso1", 32'(m1), 32'hFF);
      check("udr_count", 32'(n_underrun - u0), 2);

      // Partial frame of 5 bits, then a clean 0x43 frame.
      cs_begin();
      spi_xfer(8'hC8, 5, m0);
      cs_end(1'b1);
      byte_frame(8'h43, m0);

      // Back-to-back bytes with the holding register refilled in between.
      offer_tx(8'h12);
      u0 = n_underrun;
      exp_rx.push_back(8'h43);
      exp_rx.push_back(8'h7E);
      cs_begin();
      spi_xfer(8'h43, 8, m0);
      offer_tx(8'h34);
      spi_xfer(8'h7E, 8, m1);
      cs_end(1'b0);
      check("b2b_miso0", 32'(m0), 32'h12);
      check("b2b_miso1", 32'(m1), 32'h34);
      check("b2b_no_underrun", 32'(n_underrun - u0), 0);

      tick(4);
      check("rx_queue_drained", 32'(exp_rx.size()), 0);
      check("frame_end_drained", 32'(exp_partial.size()), 0);
      check("frame_start_count", 32'(n_fstart), 7);

      // Reset mid-stream with CS high: a byte pending and rx_data nonzero.
      offer_tx(8'h99);
      spi_sck = 1'b0; tick(3);
      spi_sck = 1'b1; tick(2);
      #3 rst = 1'b1;
      #1;
      check("mid_rst_tx_ready", 32'(tx_ready), 1);
      check("mid_rst_rx_data",  32'(rx_data), 0);
      check("mid_rst_miso",     32'(spi_miso), 1);
      check("mid_rst_oe",       32'(spi_miso_oe), 0);
      tick(2);
      rst = 1'b0;
      tick(4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

endmodule : tb_spi_slave_phy
